// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared widths and arbitration priority encoding for the SRAM-backed FIFO controller.
package sram_fifo_ctrl_pkg;

   localparam int unsigned FIFO_DATA_W = 8;
   localparam int unsigned FIFO_ADDR_W = 4;
   localparam int unsigned FIFO_DEPTH  = 1 << FIFO_ADDR_W;

   // Which side wins the SRAM port when write and read both request it
   typedef enum logic {
      PRIO_WR = 1'b0,
      PRIO_RD = 1'b1
   } prio_e;

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Producer/consumer handshakes, SRAM port and status of the SRAM FIFO controller.
interface sram_fifo_ctrl_if #(
   parameter int unsigned DATA_W = sram_fifo_ctrl_pkg::FIFO_DATA_W,
   parameter int unsigned ADDR_W = sram_fifo_ctrl_pkg::FIFO_ADDR_W
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] sram_address;
   logic [DATA_W-1:0] sram_data_in;
   logic              sram_control;
   logic [DATA_W-1:0] sram_data_out;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;

   // Environment side: producer, consumer and the SRAM itself
   modport master (
      output in_valid, in_data, out_ready, sram_data_out,
      input  in_ready, out_valid, out_data, sram_address, sram_data_in,
             sram_control, count, full, empty
   );

   // Controller side
   modport slave (
      input  in_valid, in_data, out_ready, sram_data_out,
      output in_ready, out_valid, out_data, sram_address, sram_data_in,
             sram_control, count, full, empty
   );

endinterface

// File: rtl/sram_port_arb.sv
// Shares the single SRAM port between write and read requests; priority flips only on conflict.
module sram_port_arb
   import sram_fifo_ctrl_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_wr_req,
   input  logic  i_rd_req,
   output logic  o_wr_grant,
   output logic  o_rd_grant,
   output prio_e o_prio
);

   prio_e r_prio;
   logic  w_conflict;

   assign w_conflict = i_wr_req && i_rd_req;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prio <= PRIO_WR;
      end else if (w_conflict) begin
         r_prio <= (r_prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
      end
   end

   assign o_wr_grant = i_wr_req && (!i_rd_req || (r_prio == PRIO_WR));
   assign o_rd_grant = i_rd_req && (!i_wr_req || (r_prio == PRIO_RD));
   assign o_prio     = r_prio;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO front-end owning a single-port SRAM (sync write, async read) plus a one-word head register.
module sram_fifo_ctrl
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
   input logic              i_clk,
   input logic              i_rst,
   sram_fifo_ctrl_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   logic [CNT_W-1:0]  r_mem_count;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;

   logic  w_full;
   logic  w_wr_req;
   logic  w_rd_req;
   logic  w_wr_grant;
   logic  w_rd_grant;
   prio_e w_prio;

   assign w_full   = (r_mem_count == CNT_W'(DEPTH));
   assign w_wr_req = bus.in_valid && !w_full;
   // Refill the head register when it is empty or being consumed this cycle
   assign w_rd_req = (r_mem_count != '0) && (!r_out_valid || bus.out_ready);

   sram_port_arb u_arb (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr_req   (w_wr_req),
      .i_rd_req   (w_rd_req),
      .o_wr_grant (w_wr_grant),
      .o_rd_grant (w_rd_grant),
      .o_prio     (w_prio)
   );

   // Ready does not look at in_valid, so in_valid && in_ready equals the write grant
   assign bus.in_ready     = !w_full && !(w_rd_req && (w_prio == PRIO_RD));
   assign bus.sram_control = w_wr_grant && !i_rst;
   assign bus.sram_address = w_wr_grant ? r_wptr : r_rptr;
   assign bus.sram_data_in = bus.in_data;

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.count     = r_mem_count + CNT_W'(r_out_valid);
   assign bus.full      = w_full;
   assign bus.empty     = (r_mem_count == '0) && !r_out_valid;

   // Pointers wrap naturally at DEPTH; at most one of the grants is ever active
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_mem_count <= '0;
      end else begin
         if (w_wr_grant) begin
            r_wptr      <= r_wptr + ADDR_W'(1);
            r_mem_count <= r_mem_count + CNT_W'(1);
         end else if (w_rd_grant) begin
            r_rptr      <= r_rptr + ADDR_W'(1);
            r_mem_count <= r_mem_count - CNT_W'(1);
         end
      end
   end

   // Head register: a read grant refills it in the same edge as a pop, so no bubble
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_rd_grant) begin
         r_out_valid <= 1'b1;
         r_out_data  <= bus.sram_data_out;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl driving a behavioural single-port SRAM.
`timescale 1ns/1ps
module tb_sram_fifo_ctrl;
   import sram_fifo_ctrl_pkg::*;

   localparam int unsigned DW = FIFO_DATA_W;
   localparam int unsigned AW = FIFO_ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #1000 clk = ~clk;

   sram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   sram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Behavioural single_SRAM: write on clock edge when control=1, asynchronous read
   logic [DW-1:0] sram_mem [2**AW];
   always @(posedge clk) begin
      if (bus.sram_control) sram_mem[bus.sram_address] <= bus.sram_data_in;
   end
   assign bus.sram_data_out = sram_mem[bus.sram_address];

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] sb [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: record handshakes against the scoreboard, then advance to the next negedge
   task automatic tick(output logic acc);
      logic [DW-1:0] exp;
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
         check_eq("wr_ctrl", 32'(bus.sram_control), 1);
         sb.push_back(bus.in_data);
      end
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 1);
         end else begin
            exp = sb.pop_front();
            check_eq("pop_data", 32'(bus.out_data), 32'(exp));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      logic got;
      got = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      for (int k = 0; k < 40 && !got; k++) tick(got);
      check_eq("push_accepted", 32'(got), 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      logic dummy;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < max_cycles && !bus.empty; k++) tick(dummy);
      check_eq("drain_empty", 32'(bus.empty), 1);
      check_eq("drain_sb_left", 32'(sb.size()), 0);
   endtask

   initial begin
      #40_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      logic prev_ir, prev_ov, ir, ov;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      prev_ir = 1'b0;
      prev_ov = 1'b1;

      // Reset held: control stays low even with a pending push
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b1;
      #1;
      check_eq("rst_ctrl", 32'(bus.sram_control), 0);
      check_eq("rst_count", 32'(bus.count), 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Idle after reset
      for (int k = 0; k < 4; k++) begin
         check_eq("idle_ov", 32'(bus.out_valid), 0);
         check_eq("idle_empty", 32'(bus.empty), 1);
         check_eq("idle_full", 32'(bus.full), 0);
         check_eq("idle_count", 32'(bus.count), 0);
         check_eq("idle_ctrl", 32'(bus.sram_control), 0);
         tick(acc);
      end

      // Single push A5 with consumer ready: two-cycle latency
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hA5;
      #1;
      check_eq("p1_ctrl", 32'(bus.sram_control), 1);
      check_eq("p1_addr", 32'(bus.sram_address), 0);
      tick(acc);
      check_eq("p1_acc", 32'(acc), 1);
      bus.in_valid = 1'b0;
      check_eq("p1_count_a", 32'(bus.count), 1);
      check_eq("p1_ov_a", 32'(bus.out_valid), 0);
      tick(acc);
      check_eq("p1_ov_b", 32'(bus.out_valid), 1);
      check_eq("p1_data", 32'(bus.out_data), 32'h0000_00A5);
      check_eq("p1_count_b", 32'(bus.count), 1);
      tick(acc);
      check_eq("p1_count_c", 32'(bus.count), 0);
      check_eq("p1_empty", 32'(bus.empty), 1);

      // Fill to capacity (16 in SRAM + 1 in head register)
      bus.out_ready = 1'b0;
      for (int i = 0; i < 17; i++) push_word(DW'(i));
      check_eq("fill_count", 32'(bus.count), 17);
      check_eq("fill_full", 32'(bus.full), 1);
      check_eq("fill_in_ready", 32'(bus.in_ready), 0);
      check_eq("fill_head", 32'(bus.out_data), 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      for (int k = 0; k < 3; k++) begin
         tick(acc);
         check_eq("hold_off", 32'(acc), 0);
      end
      drain(60);

      // Random push/pop traffic; pointers wrap well past 15
      for (int k = 0; k < 60; k++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_data   = DW'($urandom);
         bus.out_ready = 1'($urandom_range(0, 1));
         tick(acc);
      end
      drain(60);

      // Conflict: head full, 3 words in SRAM, both sides always requesting
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(DW'(8'h40 + i));
      check_eq("conf_count", 32'(bus.count), 4);
      check_eq("conf_ov", 32'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.in_data = DW'(8'h50 + k);
         #1;
         ir = bus.in_ready;
         ov = bus.out_valid;
         if (k > 0) begin
            check_eq("conf_alt", 32'(ir), 32'(!prev_ir));
            check_eq("conf_stall", 32'(ov || prev_ov), 1);
         end
         prev_ir = ir;
         prev_ov = ov;
         tick(acc);
      end
      drain(60);

      // Asynchronous reset in the middle of a burst
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(DW'(8'h60 + i));
      check_eq("mid_count", 32'(bus.count), 5);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      #300;
      rst = 1'b1;
      #1;
      check_eq("arst_ov", 32'(bus.out_valid), 0);
      check_eq("arst_count", 32'(bus.count), 0);
      check_eq("arst_empty", 32'(bus.empty), 1);
      check_eq("arst_full", 32'(bus.full), 0);
      check_eq("arst_ctrl", 32'(bus.sram_control), 0);
      check_eq("arst_data", 32'(bus.out_data), 0);
      sb.delete();
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push_word(8'h3C);
      check_eq("post_count", 32'(bus.count), 1);
      drain(10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
